// File: rtl/turret_sprite_fetch.sv
// Turret sprite fetch: hit test against frame-shadowed sprite position,
// ROM address generation, and a two-strobe pipeline to the palette lookup.
module turret_sprite_fetch #(
    parameter int unsigned SPRITE_W = 32,
    parameter int unsigned SPRITE_H = 32,
    parameter int unsigned FRAMES   = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        pix_en,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  turret_x_in,
    input  logic [9:0]  turret_y_in,
    input  logic [2:0]  frame_sel_in,
    input  logic        turret_en_in,
    output logic [12:0] rom_addr,
    output logic        rom_rd,
    input  logic [7:0]  rom_data,
    output logic [7:0]  pal_index,
    output logic        pix_opaque,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y
);

    localparam int unsigned CRD_W  = 10;
    localparam int unsigned DIFF_W = 11;
    localparam int unsigned FRM_W  = 3;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned PAL_W  = 8;
    localparam int unsigned COL_W  = $clog2(SPRITE_W);
    localparam int unsigned ROW_W  = $clog2(SPRITE_H);

    localparam logic [DIFF_W-1:0] SPR_W_D   = DIFF_W'(SPRITE_W);
    localparam logic [DIFF_W-1:0] SPR_H_D   = DIFF_W'(SPRITE_H);
    localparam logic [FRM_W:0]    FRAMES_D  = (FRM_W+1)'(FRAMES);
    localparam logic [FRM_W-1:0]  FRAME_MAX = FRM_W'(FRAMES - 1);

    // Shadowed sprite state (changes only on frame_start)
    logic [CRD_W-1:0]  sh_x_q, sh_x_d;
    logic [CRD_W-1:0]  sh_y_q, sh_y_d;
    logic [FRM_W-1:0]  sh_frame_q, sh_frame_d;
    logic              sh_en_q, sh_en_d;

    // Stage A registers
    logic              hit_a_q, hit_a_d;
    logic [CRD_W-1:0]  x_a_q, x_a_d;
    logic [CRD_W-1:0]  y_a_q, y_a_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_rd_q, rom_rd_d;

    // Stage B registers
    logic [PAL_W-1:0]  pal_q, pal_d;
    logic              opaque_q, opaque_d;
    logic [CRD_W-1:0]  x_b_q, x_b_d;
    logic [CRD_W-1:0]  y_b_q, y_b_d;

    // Hit-test intermediates
    logic [DIFF_W-1:0] dx_c, dy_c;
    logic              hit_c;
    logic [FRM_W-1:0]  frame_clamp_c;

    // Clip with 11-bit differences: no wrap from column 1023 back to 0
    always_comb begin
        dx_c  = {1'b0, DrawX} - {1'b0, sh_x_q};
        dy_c  = {1'b0, DrawY} - {1'b0, sh_y_q};
        hit_c = sh_en_q && (DrawX >= sh_x_q) && (DrawY >= sh_y_q)
                && (dx_c < SPR_W_D) && (dy_c < SPR_H_D);
        frame_clamp_c = ({1'b0, frame_sel_in} >= FRAMES_D) ? FRAME_MAX : frame_sel_in;
    end

    // Next-state for shadows and both pipeline stages
    always_comb begin
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_frame_d = sh_frame_q;
        sh_en_d    = sh_en_q;
        hit_a_d    = hit_a_q;
        x_a_d      = x_a_q;
        y_a_d      = y_a_q;
        rom_addr_d = rom_addr_q;
        rom_rd_d   = 1'b0;
        pal_d      = pal_q;
        opaque_d   = opaque_q;
        x_b_d      = x_b_q;
        y_b_d      = y_b_q;

        if (frame_start) begin
            sh_x_d     = turret_x_in;
            sh_y_d     = turret_y_in;
            sh_frame_d = frame_clamp_c;
            sh_en_d    = turret_en_in;
        end

        if (pix_en) begin
            hit_a_d = hit_c;
            x_a_d   = DrawX;
            y_a_d   = DrawY;
            if (hit_c) begin
                rom_addr_d = ADDR_W'({sh_frame_q, dy_c[ROW_W-1:0], dx_c[COL_W-1:0]});
                rom_rd_d   = 1'b1;
            end

            if (hit_a_q) begin
                pal_d    = rom_data;
                opaque_d = (rom_data != '0);
            end else begin
                pal_d    = '0;
                opaque_d = 1'b0;
            end
            x_b_d = x_a_q;
            y_b_d = y_a_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_frame_q <= '0;
            sh_en_q    <= 1'b0;
            hit_a_q    <= 1'b0;
            x_a_q      <= '0;
            y_a_q      <= '0;
            rom_addr_q <= '0;
            rom_rd_q   <= 1'b0;
            pal_q      <= '0;
            opaque_q   <= 1'b0;
            x_b_q      <= '0;
            y_b_q      <= '0;
        end else begin
            sh_x_q     <= sh_x_d;
            sh_y_q     <= sh_y_d;
            sh_frame_q <= sh_frame_d;
            sh_en_q    <= sh_en_d;
            hit_a_q    <= hit_a_d;
            x_a_q      <= x_a_d;
            y_a_q      <= y_a_d;
            rom_addr_q <= rom_addr_d;
            rom_rd_q   <= rom_rd_d;
            pal_q      <= pal_d;
            opaque_q   <= opaque_d;
            x_b_q      <= x_b_d;
            y_b_q      <= y_b_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rom_rd     = rom_rd_q;
    assign pal_index  = pal_q;
    assign pix_opaque = opaque_q;
    assign pix_x      = x_b_q;
    assign pix_y      = y_b_q;

endmodule

// File: tb/tb_turret_sprite_fetch.sv
// Directed bench for turret_sprite_fetch: vector table plus corner sequences.
module tb_turret_sprite_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  draw_x = '0;
    logic [9:0]  draw_y = '0;
    logic [9:0]  tx_in = '0;
    logic [9:0]  ty_in = '0;
    logic [2:0]  fsel_in = '0;
    logic        ten_in = 1'b0;
    logic [12:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data = '0;
    logic [7:0]  pal_index;
    logic        pix_opaque;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;

    int n_vec = 0;
    int n_err = 0;
    int rd_cnt = 0;

    turret_sprite_fetch #(.SPRITE_W(32), .SPRITE_H(32), .FRAMES(6)) dut (
        .Clk(clk), .Reset_n(rst_n), .pix_en(pix_en), .frame_start(frame_start),
        .DrawX(draw_x), .DrawY(draw_y), .turret_x_in(tx_in), .turret_y_in(ty_in),
        .frame_sel_in(fsel_in), .turret_en_in(ten_in), .rom_addr(rom_addr),
        .rom_rd(rom_rd), .rom_data(rom_data), .pal_index(pal_index),
        .pix_opaque(pix_opaque), .pix_x(pix_x), .pix_y(pix_y)
    );

    always #5 clk = ~clk;

    // Count every ROM read pulse seen on a clock edge
    always @(posedge clk) if (rom_rd) rd_cnt <= rd_cnt + 1;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  rom;
        logic        exp_rd;
        logic [12:0] exp_addr;
        logic [7:0]  exp_pal;
        logic        exp_opq;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic strobe(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        draw_x = x;
        draw_y = y;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic load(input logic [9:0] x, input logic [9:0] y, input logic [2:0] f, input logic en);
        @(negedge clk);
        tx_in = x;
        ty_in = y;
        fsel_in = f;
        ten_in = en;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] pal, input logic opq,
                              input logic [9:0] px, input logic [9:0] py);
        check({tag, ".pal"}, 32'(pal_index), 32'(pal));
        check({tag, ".opq"}, 32'(pix_opaque), 32'(opq));
        check({tag, ".px"}, 32'(pix_x), 32'(px));
        check({tag, ".py"}, 32'(pix_y), 32'(py));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // Sprite at (100,50), frame 5
        vecs[0] = '{10'd100, 10'd50, 8'h07, 1'b1, 13'd5120, 8'h07, 1'b1};
        vecs[1] = '{10'd131, 10'd81, 8'h3C, 1'b1, 13'd6143, 8'h3C, 1'b1};
        vecs[2] = '{10'd132, 10'd81, 8'h55, 1'b0, 13'd0,    8'h00, 1'b0};
        vecs[3] = '{10'd99,  10'd50, 8'h11, 1'b0, 13'd0,    8'h00, 1'b0};
        vecs[4] = '{10'd110, 10'd60, 8'h00, 1'b1, 13'd5450, 8'h00, 1'b0};
        vecs[5] = '{10'd100, 10'd82, 8'h22, 1'b0, 13'd0,    8'h00, 1'b0};
        vecs[6] = '{10'd115, 10'd49, 8'h33, 1'b0, 13'd0,    8'h00, 1'b0};

        // Reset state
        #12;
        check("rst.addr", 32'(rom_addr), 32'd0);
        check("rst.rd", 32'(rom_rd), 32'd0);
        check_outs("rst", 8'h00, 1'b0, 10'd0, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: stage-A check, then a flush strobe to see stage-B output
        load(10'd100, 10'd50, 3'd5, 1'b1);
        for (int i = 0; i < 7; i++) begin
            strobe(vecs[i].x, vecs[i].y);
            check($sformatf("v%0d.rd", i), 32'(rom_rd), 32'(vecs[i].exp_rd));
            if (vecs[i].exp_rd)
                check($sformatf("v%0d.addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
            rom_data = vecs[i].rom;
            strobe(10'd0, 10'd0);
            check($sformatf("v%0d.flush_rd", i), 32'(rom_rd), 32'd0);
            check_outs($sformatf("v%0d", i), vecs[i].exp_pal, vecs[i].exp_opq, vecs[i].x, vecs[i].y);
        end

        // Shadowing: live input change without frame_start has no effect
        tx_in = 10'd200;
        strobe(10'd100, 10'd50);
        check("shadow.old_hit", 32'(rom_rd), 32'd1);
        check("shadow.old_addr", 32'(rom_addr), 32'd5120);
        strobe(10'd200, 10'd50);
        check("shadow.new_miss", 32'(rom_rd), 32'd0);

        // frame_start coincident with pix_en: this pixel uses old x
        @(negedge clk);
        draw_x = 10'd100;
        draw_y = 10'd50;
        pix_en = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        frame_start = 1'b0;
        check("coinc.rd", 32'(rom_rd), 32'd1);
        check("coinc.addr", 32'(rom_addr), 32'd5120);
        rom_data = 8'h09;
        strobe(10'd201, 10'd50);
        check("after.rd", 32'(rom_rd), 32'd1);
        check("after.addr", 32'(rom_addr), 32'd5121);
        check_outs("coinc", 8'h09, 1'b1, 10'd100, 10'd50);
        strobe(10'd100, 10'd50);
        check("after.old_miss", 32'(rom_rd), 32'd0);
        check_outs("after", 8'h09, 1'b1, 10'd201, 10'd50);

        // Stall: pix_en low for 10 cycles, inputs wiggle, nothing moves
        rom_data = 8'hEE;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            draw_x = 10'(300 + c);
            check($sformatf("stall%0d.rd", c), 32'(rom_rd), 32'd0);
        end
        check("stall.addr", 32'(rom_addr), 32'd5121);
        check_outs("stall", 8'h09, 1'b1, 10'd201, 10'd50);

        // Clip near right edge and frame clamp (7 -> 5 with 6 frames)
        load(10'd1000, 10'd0, 3'd7, 1'b1);
        strobe(10'd1023, 10'd0);
        check("clip.rd", 32'(rom_rd), 32'd1);
        check("clip.addr", 32'(rom_addr), 32'd5143);
        rom_data = 8'h42;
        strobe(10'd0, 10'd0);
        check("nowrap.rd", 32'(rom_rd), 32'd0);
        check_outs("clip", 8'h42, 1'b1, 10'd1023, 10'd0);
        strobe(10'd1023, 10'd31);
        check("clip2.addr", 32'(rom_addr), 32'd6135);
        check_outs("nowrap", 8'h00, 1'b0, 10'd0, 10'd0);

        // Unclamped frame 4 for contrast
        load(10'd1000, 10'd0, 3'd4, 1'b1);
        strobe(10'd1001, 10'd1);
        check("frame4.addr", 32'(rom_addr), 32'd4129);

        // Disabled sprite: no ROM reads anywhere in the frame
        load(10'd100, 10'd50, 3'd5, 1'b0);
        rd_cnt = 0;
        rom_data = 8'h77;
        strobe(10'd100, 10'd50);
        strobe(10'd110, 10'd60);
        strobe(10'd131, 10'd81);
        check("disabled.rd_cnt", 32'(rd_cnt), 32'd0);
        check("disabled.opq", 32'(pix_opaque), 32'd0);

        // Mid-line reset with live outputs
        load(10'd100, 10'd50, 3'd5, 1'b1);
        rom_data = 8'h5A;
        strobe(10'd100, 10'd50);
        strobe(10'd101, 10'd50);
        check("prerst.opq", 32'(pix_opaque), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst.addr", 32'(rom_addr), 32'd0);
        check("midrst.rd", 32'(rom_rd), 32'd0);
        check_outs("midrst", 8'h00, 1'b0, 10'd0, 10'd0);
        @(negedge clk);
        rst_n = 1'b1;
        strobe(10'd100, 10'd50);
        check("hidden.rd", 32'(rom_rd), 32'd0);
        load(10'd100, 10'd50, 3'd5, 1'b1);
        rom_data = 8'h07;
        strobe(10'd100, 10'd50);
        check("refill.rd", 32'(rom_rd), 32'd1);
        check("refill.addr", 32'(rom_addr), 32'd5120);
        check_outs("refill1", 8'h00, 1'b0, 10'd100, 10'd50);
        strobe(10'd0, 10'd0);
        check_outs("refill2", 8'h07, 1'b1, 10'd100, 10'd50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
